gen_ramp_multi: RTL and testbench

GEN_RAMP_MULTI -- requirements
Module: gen_ramp_multi

---
 rtl/gen_ramp_multi.sv | 188 ++++++++++++++++++
 tb/tb_gen_ramp_multi.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_ramp_multi.sv
// Programmable ramp generator (triangle / saw-up / saw-down / single sweep) with
// NCH fixed-point scaled copies of the ramp through a multiply-then-saturate pipe.
module gen_ramp_multi #(
    parameter int R   = 14,
    parameter int NCH = 2,
    parameter int CW  = 32,
    parameter int FW  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CW-1:0]    i_ramp_step,
    input  logic [R-1:0]     i_ramp_inc,
    input  logic [R-1:0]     i_ramp_low_lim,
    input  logic [R-1:0]     i_ramp_hig_lim,
    input  logic [1:0]       i_ramp_mode,
    input  logic             i_ramp_dir,
    input  logic             i_ramp_enable,
    input  logic             i_ramp_reset,
    input  logic [NCH*R-1:0] i_ramp_factor,
    output logic [R-1:0]     o_out_ramp,
    output logic [NCH*R-1:0] o_out_ch,
    output logic             o_trig_low,
    output logic             o_trig_hig,
    output logic             o_sweep_done,
    output logic             o_lim_err
);

    typedef enum logic [1:0] {S_UP, S_DOWN, S_DONE, S_ERR} state_t;

    localparam int RX = R + 2;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic signed [2*R-1:0] SAT_HI = {{(R+1){1'b0}}, {(R-1){1'b1}}};
    localparam logic signed [2*R-1:0] SAT_LO = {{(R+1){1'b1}}, {(R-1){1'b0}}};

    state_t              r_state;
    logic signed [R-1:0] r_ramp;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       r_step_q;
    logic [1:0]          r_mode_q;
    logic                r_trig_low;
    logic                r_trig_hig;
    logic                r_done;
    logic                r_err;

    logic signed [R-1:0]  w_lo;
    logic signed [R-1:0]  w_hi;
    logic [R-1:0]         w_inc;
    logic signed [RX-1:0] w_ramp_x;
    logic signed [RX-1:0] w_lo_x;
    logic signed [RX-1:0] w_hi_x;
    logic signed [RX-1:0] w_sum;
    logic signed [RX-1:0] w_dif;
    logic signed [R-1:0]  w_up_nxt;
    logic signed [R-1:0]  w_dn_nxt;
    logic signed [R-1:0]  w_nxt;
    logic                 w_chg;
    logic                 w_go;
    logic                 w_bad;
    logic                 w_start_up;

    assign w_lo  = $signed(i_ramp_low_lim);
    assign w_hi  = $signed(i_ramp_hig_lim);
    assign w_inc = (i_ramp_inc == '0) ? {{(R-1){1'b0}}, 1'b1} : i_ramp_inc;

    // Two guard bits so ramp +/- inc never wraps before clamping.
    assign w_ramp_x = {{2{r_ramp[R-1]}}, r_ramp};
    assign w_lo_x   = {{2{w_lo[R-1]}}, w_lo};
    assign w_hi_x   = {{2{w_hi[R-1]}}, w_hi};
    assign w_sum    = w_ramp_x + $signed({2'b00, w_inc});
    assign w_dif    = w_ramp_x - $signed({2'b00, w_inc});
    assign w_up_nxt = (w_sum > w_hi_x) ? w_hi : w_sum[R-1:0];
    assign w_dn_nxt = (w_dif < w_lo_x) ? w_lo : w_dif[R-1:0];

    assign w_chg      = (i_ramp_step != r_step_q) || (i_ramp_mode != r_mode_q);
    assign w_go       = (r_cnt == i_ramp_step) && i_ramp_enable && !i_ramp_reset;
    assign w_bad      = (w_lo >= w_hi);
    assign w_start_up = (i_ramp_mode == 2'b01) || (i_ramp_mode == 2'b11) ||
                        ((i_ramp_mode == 2'b00) && !i_ramp_dir);

    // Out-of-limit values (limits moved mid-run) snap to the violated limit first.
    always_comb begin
        w_nxt = r_ramp;
        if (w_ramp_x > w_hi_x)
            w_nxt = w_hi;
        else if (w_ramp_x < w_lo_x)
            w_nxt = w_lo;
        else begin
            case (i_ramp_mode)
                2'b00:   w_nxt = (r_state == S_DOWN) ? w_dn_nxt : w_up_nxt;
                2'b01:   w_nxt = (r_ramp == w_hi) ? w_lo : w_up_nxt;
                2'b10:   w_nxt = (r_ramp == w_lo) ? w_hi : w_dn_nxt;
                default: w_nxt = w_up_nxt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_UP;
            r_ramp     <= '0;
            r_cnt      <= '0;
            r_step_q   <= '0;
            r_mode_q   <= '0;
            r_trig_low <= 1'b0;
            r_trig_hig <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_step_q <= i_ramp_step;
            r_mode_q <= i_ramp_mode;
            if (i_ramp_reset || w_chg)
                r_cnt <= '0;
            else if (i_ramp_enable)
                r_cnt <= (r_cnt == i_ramp_step) ? '0 : r_cnt + CNT_ONE;

            r_trig_low <= 1'b0;
            r_trig_hig <= 1'b0;
            if (w_bad) begin
                r_state <= S_ERR;
                r_ramp  <= w_lo;
                r_err   <= 1'b1;
                r_done  <= 1'b0;
            end else if (i_ramp_reset) begin
                r_state <= w_start_up ? S_UP : S_DOWN;
                r_ramp  <= w_start_up ? w_lo : w_hi;
                r_err   <= 1'b0;
                r_done  <= 1'b0;
            end else if (w_go && (r_state == S_UP || r_state == S_DOWN)) begin
                r_ramp     <= w_nxt;
                r_trig_low <= (w_nxt == w_lo) && !r_trig_low;
                r_trig_hig <= (w_nxt == w_hi) && !r_trig_hig;
                case (i_ramp_mode)
                    2'b00: begin
                        if (w_nxt == w_hi)
                            r_state <= S_DOWN;
                        else if (w_nxt == w_lo)
                            r_state <= S_UP;
                    end
                    2'b01: r_state <= S_UP;
                    2'b10: r_state <= S_DOWN;
                    default: begin
                        if (w_nxt == w_hi) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_UP;
                        end
                    end
                endcase
            end
        end
    end

    assign o_out_ramp   = r_ramp;
    assign o_trig_low   = r_trig_low;
    assign o_trig_hig   = r_trig_hig;
    assign o_sweep_done = r_done;
    assign o_lim_err    = r_err;

    // Stage 1 registers the full product, stage 2 the shifted and saturated sample.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic signed [2*R-1:0] w_ramp_w;
        logic signed [2*R-1:0] w_fac_w;
        logic signed [2*R-1:0] w_sh;
        logic signed [R-1:0]   w_sat;
        logic signed [2*R-1:0] r_prod;
        logic signed [R-1:0]   r_ch;

        assign w_ramp_w = {{R{r_ramp[R-1]}}, r_ramp};
        assign w_fac_w  = {{R{i_ramp_factor[g*R+R-1]}}, i_ramp_factor[g*R +: R]};
        assign w_sh     = r_prod >>> FW;
        assign w_sat    = (w_sh > SAT_HI) ? SAT_HI[R-1:0] :
                          (w_sh < SAT_LO) ? SAT_LO[R-1:0] : w_sh[R-1:0];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_prod <= '0;
                r_ch   <= '0;
            end else begin
                r_prod <= w_ramp_w * w_fac_w;
                r_ch   <= w_sat;
            end
        end

        assign o_out_ch[g*R +: R] = r_ch;
    end

endmodule

// File: tb/tb_gen_ramp_multi.sv
// Bench for gen_ramp_multi: integer reference model compared every cycle, plus
// directed literal scenarios for the triangle, saw, sweep, gain, limit and reset cases.
module tb_gen_ramp_multi;

    localparam int R   = 14;
    localparam int NCH = 2;
    localparam int CW  = 32;
    localparam int FW  = 12;
    localparam int MAXV = (1 << (R-1)) - 1;
    localparam int MINV = -(1 << (R-1));
    localparam int UP = 0, DN = 1, DONE = 2, ERRS = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CW-1:0]    ramp_step;
    logic [R-1:0]     ramp_inc;
    logic [R-1:0]     ramp_low_lim;
    logic [R-1:0]     ramp_hig_lim;
    logic [1:0]       ramp_mode;
    logic             ramp_dir;
    logic             ramp_enable;
    logic             ramp_reset;
    logic [NCH*R-1:0] ramp_factor;
    logic [R-1:0]     out_ramp;
    logic [NCH*R-1:0] out_ch;
    logic             trig_low, trig_hig, sweep_done, lim_err;

    int tests = 0;
    int fails = 0;

    gen_ramp_multi #(.R(R), .NCH(NCH), .CW(CW), .FW(FW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_ramp_step    (ramp_step),
        .i_ramp_inc     (ramp_inc),
        .i_ramp_low_lim (ramp_low_lim),
        .i_ramp_hig_lim (ramp_hig_lim),
        .i_ramp_mode    (ramp_mode),
        .i_ramp_dir     (ramp_dir),
        .i_ramp_enable  (ramp_enable),
        .i_ramp_reset   (ramp_reset),
        .i_ramp_factor  (ramp_factor),
        .o_out_ramp     (out_ramp),
        .o_out_ch       (out_ch),
        .o_trig_low     (trig_low),
        .o_trig_hig     (trig_hig),
        .o_sweep_done   (sweep_done),
        .o_lim_err      (lim_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int     m_ramp, m_st, m_done, m_err, m_tl, m_th, m_mode_q;
    longint m_cnt, m_step_q;
    longint m_prod [NCH];
    int     m_ch   [NCH];
    bit     s_rst, s_dir, s_en, s_rr;
    longint s_step;
    int     s_inc, s_lo, s_hi, s_mode;
    int     s_fac  [NCH];

    function automatic int sat(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return int'(v);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_step();
        int nxt, inc, ptl, pth;
        bit go, chg, up0;
        if (!s_rst) begin
            m_ramp = 0; m_st = UP; m_done = 0; m_err = 0; m_tl = 0; m_th = 0;
            m_cnt = 0; m_step_q = 0; m_mode_q = 0;
            for (int i = 0; i < NCH; i++) begin m_prod[i] = 0; m_ch[i] = 0; end
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            m_ch[i]   = sat(m_prod[i] >>> FW);
            m_prod[i] = longint'(m_ramp) * longint'(s_fac[i]);
        end
        chg = (s_step != m_step_q) || (s_mode != m_mode_q);
        go  = (m_cnt == s_step) && s_en && !s_rr;
        if (s_rr || chg) m_cnt = 0;
        else if (s_en) m_cnt = (m_cnt == s_step) ? 0 : m_cnt + 1;
        m_step_q = s_step;
        m_mode_q = s_mode;
        ptl = m_tl; pth = m_th; m_tl = 0; m_th = 0;
        inc = (s_inc == 0) ? 1 : s_inc;
        if (s_lo >= s_hi) begin
            m_st = ERRS; m_ramp = s_lo; m_err = 1; m_done = 0;
        end else if (s_rr) begin
            up0 = (s_mode == 1) || (s_mode == 3) || (s_mode == 0 && !s_dir);
            m_ramp = up0 ? s_lo : s_hi;
            m_st = up0 ? UP : DN; m_done = 0; m_err = 0;
        end else if (go && (m_st == UP || m_st == DN)) begin
            if (m_ramp > s_hi) nxt = s_hi;
            else if (m_ramp < s_lo) nxt = s_lo;
            else if (s_mode == 1 && m_ramp == s_hi) nxt = s_lo;
            else if (s_mode == 2 && m_ramp == s_lo) nxt = s_hi;
            else if (s_mode == 2 || (s_mode == 0 && m_st == DN)) nxt = imax(m_ramp - inc, s_lo);
            else nxt = imin(m_ramp + inc, s_hi);
            m_tl = (nxt == s_lo && ptl == 0) ? 1 : 0;
            m_th = (nxt == s_hi && pth == 0) ? 1 : 0;
            m_ramp = nxt;
            if (s_mode == 0) begin
                if (nxt == s_hi) m_st = DN; else if (nxt == s_lo) m_st = UP;
            end else if (s_mode == 1) m_st = UP;
            else if (s_mode == 2) m_st = DN;
            else if (nxt == s_hi) begin m_st = DONE; m_done = 1; end
            else m_st = UP;
        end
    endtask

    // Sample inputs at the edge, compare DUT 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            s_rst = rst_n; s_step = ramp_step; s_inc = ramp_inc;
            s_lo = int'($signed(ramp_low_lim)); s_hi = int'($signed(ramp_hig_lim));
            s_mode = ramp_mode; s_dir = ramp_dir; s_en = ramp_enable; s_rr = ramp_reset;
            for (int i = 0; i < NCH; i++) s_fac[i] = int'($signed(ramp_factor[i*R +: R]));
            model_step();
            #1;
            chk("model out_ramp", $signed(out_ramp), m_ramp);
            for (int i = 0; i < NCH; i++) chk("model out_ch", $signed(out_ch[i*R +: R]), m_ch[i]);
            chk("model trig_low", trig_low, m_tl);
            chk("model trig_hig", trig_hig, m_th);
            chk("model sweep_done", sweep_done, m_done);
            chk("model lim_err", lim_err, m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_lim(input int lo, input int hi);
        ramp_low_lim = lo[R-1:0];
        ramp_hig_lim = hi[R-1:0];
    endtask

    task automatic set_inc(input int v);
        ramp_inc = v[R-1:0];
    endtask

    int saw_seq [6] = '{0, 3, 6, 9, 10, 0};
    int nh, nl, ex, lo, hi;

    initial begin
        rst_n = 1'b0; ramp_step = '0; set_inc(1); set_lim(-4, 4);
        ramp_mode = 2'b00; ramp_dir = 1'b0; ramp_enable = 1'b1; ramp_reset = 1'b0;
        ramp_factor = {14'h1FFF, 14'h0800};
        repeat (3) @(negedge clk);
        chk("reset out_ramp", out_ramp, 0);
        chk("reset out_ch", out_ch, 0);
        chk("reset flags", {trig_low, trig_hig, sweep_done, lim_err}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // triangle -4..4
        ramp_reset = 1'b1;
        @(negedge clk); ramp_reset = 1'b0;
        chk("tri load", $signed(out_ramp), -4);
        nh = 0; nl = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            ex = (k <= 8) ? k - 4 : 12 - k;
            chk("tri value", $signed(out_ramp), ex);
            nh += int'(trig_hig); nl += int'(trig_low);
        end
        chk("tri trig_hig count", nh, 1);
        chk("tri trig_low count", nl, 1);

        // saw-up 0..10 step 3, dwell 3
        ramp_mode = 2'b01; set_lim(0, 10); set_inc(3); ramp_step = 2; ramp_reset = 1'b1;
        @(negedge clk); ramp_reset = 1'b0;
        nh = 0;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) @(negedge clk);
            chk("saw value", $signed(out_ramp), saw_seq[k/3]);
            nh += int'(trig_hig);
        end
        chk("saw trig_hig count", nh, 1);

        // single sweep 0..5 inc 2
        ramp_mode = 2'b11; set_lim(0, 5); set_inc(2); ramp_step = 0; ramp_reset = 1'b1;
        @(negedge clk); ramp_reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            ex = (k == 0) ? 0 : (k == 1) ? 2 : (k == 2) ? 4 : 5;
            chk("sweep value", $signed(out_ramp), ex);
            chk("sweep done", sweep_done, (k >= 3) ? 1 : 0);
        end
        ramp_reset = 1'b1;
        @(negedge clk); ramp_reset = 1'b0;
        chk("sweep restart value", $signed(out_ramp), 0);
        chk("sweep restart done", sweep_done, 0);

        // channel gain and saturation, 2-cycle lag
        set_lim(8000, 8191); set_inc(200); ramp_reset = 1'b1;
        @(negedge clk); ramp_reset = 1'b0;
        chk("gain ramp load", $signed(out_ramp), 8000);
        @(negedge clk);
        chk("gain ramp top", $signed(out_ramp), 8191);
        @(negedge clk);
        chk("gain ch0 lag", $signed(out_ch[0 +: R]), 4000);
        @(negedge clk);
        chk("gain ch0", $signed(out_ch[0 +: R]), 4095);
        chk("gain ch1 sat", $signed(out_ch[R +: R]), 8191);

        // invalid limits
        ramp_mode = 2'b01; set_inc(5); set_lim(100, 50);
        @(negedge clk);
        chk("err flag", lim_err, 1);
        chk("err value", $signed(out_ramp), 100);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("err no trig", {trig_low, trig_hig}, 0);
        end
        set_lim(100, 200);
        @(negedge clk);
        chk("err held", lim_err, 1);
        ramp_reset = 1'b1;
        @(negedge clk); ramp_reset = 1'b0;
        chk("err cleared", lim_err, 0);
        chk("err resume load", $signed(out_ramp), 100);
        @(negedge clk);
        chk("err resume step", $signed(out_ramp), 105);

        // async reset mid-sweep with step change
        ramp_mode = 2'b00; set_lim(-20, 20); set_inc(1); ramp_step = 3; ramp_reset = 1'b1;
        @(negedge clk); ramp_reset = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0; ramp_step = 5;
        #1;
        chk("async rst ramp", out_ramp, 0);
        chk("async rst ch", out_ch, 0);
        chk("async rst flags", {trig_low, trig_hig, sweep_done, lim_err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nh = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            nh += int'(trig_low) + int'(trig_hig);
            if (k == 6) chk("release hold", $signed(out_ramp), 0);
            if (k == 7) chk("release first go", $signed(out_ramp), 1);
        end
        chk("release no trig", nh, 0);

        // randomized run
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ramp_enable = ($urandom_range(0, 9) != 0);
            ramp_reset  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 59) == 0) begin
                ramp_mode = 2'($urandom_range(0, 3));
                ramp_dir  = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 79) == 0) ramp_step = $urandom_range(0, 3);
            if ($urandom_range(0, 49) == 0) begin
                lo = int'($urandom_range(0, 400)) - 200;
                hi = lo + int'($urandom_range(0, 300)) - 30;
                set_lim(lo, hi);
            end
            if ($urandom_range(0, 59) == 0) set_inc(int'($urandom_range(0, 40)));
            if ($urandom_range(0, 299) == 0) begin
                set_lim(MINV, MAXV);
                set_inc(int'($urandom_range(4000, 16383)));
            end
            if ($urandom_range(0, 99) == 0)
                for (int i = 0; i < NCH; i++) ramp_factor[i*R +: R] = R'($urandom_range(0, 16383));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
